// File: rtl/main_mem_ctrl.sv
// rtl/main_mem_ctrl.sv - fixed-latency 128-bit block memory responder for the cache link
// Build option MEM_WORD_WRITE_EN: a write updates only word addr[3:2] instead of the whole block.
module main_mem_ctrl #(
  parameter int ADDR_W  = 10,
  parameter int BLOCK_W = 128,
  parameter int LATENCY = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic               read_write_i,
  input  logic [ADDR_W-1:0]  addr_i,
  input  logic [BLOCK_W-1:0] write_data_i,
  output logic               resp_valid_o,
  output logic [BLOCK_W-1:0] read_data_o
);

  localparam int IDX_W = ADDR_W - 4;
  localparam int NBLK  = 2 ** IDX_W;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_e;

  state_e             state_q;
  logic [3:0]         cnt_q;
  logic               rw_q;
  logic [IDX_W-1:0]   idx_q;
  logic [BLOCK_W-1:0] wdata_q;
  logic               ready_q;
  logic               resp_q;
  logic [BLOCK_W-1:0] rdata_q;
  logic               commit;

  logic [BLOCK_W-1:0] mem_q [NBLK];

`ifdef MEM_WORD_WRITE_EN
  logic [1:0] lane_q;
  logic       unused_addr;
  assign unused_addr = ^addr_i[1:0];
`else
  logic       unused_addr;
  assign unused_addr = ^addr_i[3:0];
`endif

  assign commit = (state_q == S_ACCESS) && (cnt_q == 4'd0);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      ready_q <= 1'b1;
      resp_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          resp_q <= 1'b0;
          if (req_valid_i) begin
            rw_q    <= read_write_i;
            idx_q   <= addr_i[ADDR_W-1:4];
            wdata_q <= write_data_i;
`ifdef MEM_WORD_WRITE_EN
            lane_q  <= addr_i[3:2];
`endif
            cnt_q   <= 4'(LATENCY - 1);
            ready_q <= 1'b0;
            state_q <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (cnt_q == 4'd0) begin
            if (!rw_q) rdata_q <= mem_q[idx_q];
            resp_q  <= 1'b1;
            state_q <= S_RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_RESP: begin
          resp_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
          resp_q  <= 1'b0;
        end
      endcase
    end
  end

  // Array is never cleared; reset only suppresses a pending commit.
  always_ff @(posedge clk_i) begin
    if (!reset_i && commit && rw_q) begin
`ifdef MEM_WORD_WRITE_EN
      mem_q[idx_q][{lane_q, 5'b0} +: 32] <= wdata_q[{lane_q, 5'b0} +: 32];
`else
      mem_q[idx_q] <= wdata_q;
`endif
    end
  end

  assign req_ready_o  = ready_q;
  assign resp_valid_o = resp_q;
  assign read_data_o  = rdata_q;

endmodule

// File: tb/tb_main_mem_ctrl.sv
// tb/tb_main_mem_ctrl.sv - directed self-checking bench for main_mem_ctrl (LATENCY 4 and 1 instances)
module tb_main_mem_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         v4, rw4, v1, rw1;
  logic [9:0]   a4, a1;
  logic [127:0] wd4, wd1;
  logic         rdy4, rv4, rdy1, rv1;
  logic [127:0] rd4, rd1;

  int n_asserts = 0;
  int n_fail    = 0;

  always #5 clk = ~clk;

  main_mem_ctrl #(.ADDR_W(10), .BLOCK_W(128), .LATENCY(4)) u_dut4 (
    .clk_i(clk), .reset_i(rst), .req_valid_i(v4), .req_ready_o(rdy4),
    .read_write_i(rw4), .addr_i(a4), .write_data_i(wd4),
    .resp_valid_o(rv4), .read_data_o(rd4)
  );

  main_mem_ctrl #(.ADDR_W(10), .BLOCK_W(128), .LATENCY(1)) u_dut1 (
    .clk_i(clk), .reset_i(rst), .req_valid_i(v1), .req_ready_o(rdy1),
    .read_write_i(rw1), .addr_i(a1), .write_data_i(wd1),
    .resp_valid_o(rv1), .read_data_o(rd1)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete request on the LATENCY=4 instance, checking handshake and latency.
  task automatic req4(input logic rw, input logic [9:0] a, input logic [127:0] d, input string tag);
    int cnt;
    @(negedge clk);
    chk({tag, " ready"}, 128'(rdy4), 128'd1);
    v4 = 1'b1; rw4 = rw; a4 = a; wd4 = d;
    @(negedge clk);
    v4 = 1'b0;
    chk({tag, " busy"}, 128'(rdy4), 128'd0);
    cnt = 0;
    while (rv4 !== 1'b1 && cnt < 32) begin
      @(negedge clk);
      cnt++;
    end
    chk({tag, " latency"}, 128'(cnt), 128'd4);
    @(negedge clk);
    chk({tag, " pulse"}, 128'(rv4), 128'd0);
  endtask

  localparam logic [127:0] D1 = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
  localparam logic [127:0] DY = 128'h5555_5555_6666_6666_7777_7777_8888_8888;
  localparam logic [127:0] DX = 128'h9999_9999_AAAA_AAAA_BBBB_BBBB_CCCC_CCCC;
  localparam logic [127:0] DB = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] W2 = 128'hAAAA_AAAA_DEAD_BEEF_BBBB_BBBB_CCCC_CCCC;
`ifdef MEM_WORD_WRITE_EN
  localparam logic [127:0] EXP5 = 128'h0123_4567_DEAD_BEEF_FEDC_BA98_7654_3210;
`else
  localparam logic [127:0] EXP5 = W2;
`endif
  localparam logic [127:0] DP = 128'h1357_9BDF_2468_ACE0_0F0F_0F0F_F0F0_F0F0;
  localparam logic [127:0] DQ = 128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000;
  localparam logic [127:0] DR = 128'h0000_1111_0000_2222_0000_3333_0000_4444;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rsp, acc4_n, acc1_n, rsp4_n, rsp1_n, last4, last1, rdy_hi;
    rst = 1'b1;
    v4 = 1'b0; rw4 = 1'b0; a4 = '0; wd4 = '0;
    v1 = 1'b0; rw1 = 1'b0; a1 = '0; wd1 = '0;

    // Reset and quiet idle
    repeat (2) @(negedge clk);
    chk("reset ready", 128'(rdy4), 128'd1);
    chk("reset resp", 128'(rv4), 128'd0);
    chk("reset rdata", rd4, 128'd0);
    chk("reset ready L1", 128'(rdy1), 128'd1);
    rst = 1'b0;
    rsp = 0;
    repeat (5) begin
      @(negedge clk);
      if (rv4 === 1'b1 || rv1 === 1'b1) rsp++;
    end
    chk("idle no resp", 128'(rsp), 128'd0);

    // Write then read same block via a different byte offset
    req4(1'b1, 10'h040, D1, "wr040");
    req4(1'b0, 10'h04C, 128'd0, "rd04C");
    chk("rd04C data", rd4, D1);

    // Continuous reqValid: spacing LATENCY+2, one response per accept
    acc4_n = 0; acc1_n = 0; rsp4_n = 0; rsp1_n = 0; last4 = 0; last1 = 0;
    rw4 = 1'b0; rw1 = 1'b0; a4 = 10'h040; a1 = 10'h040;
    for (int cyc = 0; cyc < 34; cyc++) begin
      @(negedge clk);
      v4 = (cyc < 24);
      v1 = (cyc < 24);
      if (rv4 === 1'b1) rsp4_n++;
      if (rv1 === 1'b1) rsp1_n++;
      if (v4 && rdy4) begin
        if (acc4_n > 0) chk("L4 spacing", 128'(cyc - last4), 128'd6);
        last4 = cyc; acc4_n++;
        a4 = (a4 == 10'h040) ? 10'h080 : 10'h040;
      end
      if (v1 && rdy1) begin
        if (acc1_n > 0) chk("L1 spacing", 128'(cyc - last1), 128'd3);
        last1 = cyc; acc1_n++;
        a1 = (a1 == 10'h040) ? 10'h080 : 10'h040;
      end
    end
    chk("L4 accepts", 128'(acc4_n), 128'd4);
    chk("L4 resps", 128'(rsp4_n), 128'd4);
    chk("L1 accepts", 128'(acc1_n), 128'd8);
    chk("L1 resps", 128'(rsp1_n), 128'd8);

    // Reset during ACCESS drops an uncommitted write
    req4(1'b1, 10'h3F0, DY, "wr3F0 old");
    @(negedge clk);
    v4 = 1'b1; rw4 = 1'b1; a4 = 10'h3F0; wd4 = DX;
    @(negedge clk);
    v4 = 1'b0;
    rsp = 0;
    repeat (2) begin
      @(negedge clk);
      if (rv4 === 1'b1) rsp++;
    end
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (rv4 === 1'b1) rsp++;
    end
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (rv4 === 1'b1) rsp++;
    end
    chk("abort no resp", 128'(rsp), 128'd0);
    chk("abort rdata cleared", rd4, 128'd0);
    req4(1'b0, 10'h3F0, 128'd0, "rd3F0");
    chk("rd3F0 old data", rd4, DY);

    // Word-lane write vs full-block write; readData holds through writes
    req4(1'b1, 10'h080, DB, "wr080");
    req4(1'b0, 10'h080, 128'd0, "rd080");
    chk("rd080 data", rd4, DB);
    req4(1'b1, 10'h088, W2, "wr088");
    chk("rdata holds over write", rd4, DB);
    req4(1'b0, 10'h084, 128'd0, "rd084");
    chk("lane write result", rd4, EXP5);

    // Input changes while busy are ignored
    req4(1'b1, 10'h140, DR, "wr140");
    @(negedge clk);
    v4 = 1'b1; rw4 = 1'b1; a4 = 10'h100; wd4 = DP;
    @(negedge clk);
    rsp = 0; rdy_hi = 0;
    for (int i = 0; i < 5; i++) begin
      if (rv4 === 1'b1) rsp++;
      if (rdy4 === 1'b1) rdy_hi++;
      v4 = (i % 2 == 0);
      a4 = 10'h140; wd4 = DQ; rw4 = 1'b1;
      @(negedge clk);
    end
    v4 = 1'b0;
    chk("busy single resp", 128'(rsp), 128'd1);
    chk("busy not ready", 128'(rdy_hi), 128'd0);
    req4(1'b0, 10'h100, 128'd0, "rd100");
    chk("latched data 100", rd4, DP);
    req4(1'b0, 10'h140, 128'd0, "rd140");
    chk("untouched 140", rd4, DR);

    // Wrap-around: upper address bits beyond ADDR_W do not exist, top block reachable
    req4(1'b0, 10'h3FF, 128'd0, "rd3FF");
    chk("rd3FF data", rd4, DY);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
